result_memory_bank: RTL and testbench

Parametrised result store for the convolution datapath: captures output-matrix elements from NUM_CH compute engines (channel 0 = PE, 1 = 3×3 SA, 2 = 2×2 SA by default) into per-channel banks and tracks per-channel completion. Once every channel has filled its bank, a sequential compare engine checks all banks against channel 0, one element per cycle, and reports agreement. It generalises the fixed C11..C22 one-hot strobe store to any width, output dimension and engine count, and adds a valid/ready handshake, a read port, error flags and cross-engine checking.

---
 rtl/result_memory_bank.sv | 210 +++++++++++++++++++++
 tb/tb_result_memory_bank.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/result_memory_bank.sv
// result_memory_bank
//   Result store for the convolution datapath. Each of NUM_CH compute engines
//   writes OUT_DIM x OUT_DIM output elements into its own bank. A per-bank
//   written mask tracks which elements have arrived. When every bank is full,
//   a sequential engine compares each bank against bank 0, one element per
//   cycle, and then reports whether they all agree.
//
// Ports
//   clk          rising-edge clock
//   rst_memory_n synchronous active-low reset
//   clr          clears masks, flags and the FSM; bank contents are kept
//   wr_valid     per-channel write request
//   wr_ready     shared write ready, high only while idle
//   wr_addr      packed per-channel row-major element addresses
//   wr_data      packed per-channel element data
//   rd_en        read strobe
//   rd_ch        read channel
//   rd_addr      read element address
//   rd_data      registered read data; 0 for an out-of-range channel/address
//   ch_done      per-channel "bank fully written"
//   cmp_busy     compare in progress
//   cmp_done     compare finished; held until clr or reset
//   all_match    valid with cmp_done: every bank equals bank 0
//   mism_addr    first mismatching address (0 if none)
//   ovw_err      sticky: write to an element that was already written
//   addr_err     sticky: write with an address beyond the bank
module result_memory_bank #(
  parameter int DATA_W  = 8,
  parameter int NUM_CH  = 3,
  parameter int OUT_DIM = 2,
  localparam int DEPTH  = OUT_DIM * OUT_DIM,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_memory_n,
  input  logic                     clr,
  input  logic [NUM_CH-1:0]        wr_valid,
  output logic                     wr_ready,
  input  logic [NUM_CH*ADDR_W-1:0] wr_addr,
  input  logic [NUM_CH*DATA_W-1:0] wr_data,
  input  logic                     rd_en,
  input  logic [CH_W-1:0]          rd_ch,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic [NUM_CH-1:0]        ch_done,
  output logic                     cmp_busy,
  output logic                     cmp_done,
  output logic                     all_match,
  output logic [ADDR_W-1:0]        mism_addr,
  output logic                     ovw_err,
  output logic                     addr_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem  [NUM_CH][DEPTH];
  logic [DEPTH-1:0]    mask [NUM_CH];
  logic [ADDR_W-1:0]   idx;
  logic                mismatch;

  logic [ADDR_W-1:0]   wa [NUM_CH];
  logic [DATA_W-1:0]   wd [NUM_CH];
  logic [NUM_CH-1:0]   wr_hit;
  logic [NUM_CH-1:0]   wr_bad;
  logic [NUM_CH-1:0]   wr_ovw;
  logic [DATA_W-1:0]   rd_mux;
  logic                cmp_miss;

  assign wr_ready = (state == S_IDLE);

  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      ch_done[c] = &mask[c];
    end
  end

  // Write decode. Banks are indexed through a loop compare so an address
  // beyond DEPTH never forms an out-of-range array index.
  always_comb begin
    wr_hit = '0;
    wr_bad = '0;
    wr_ovw = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      wa[c] = wr_addr[c*ADDR_W +: ADDR_W];
      wd[c] = wr_data[c*DATA_W +: DATA_W];
      if (wr_valid[c] && wr_ready) begin
        if (int'(wa[c]) < DEPTH) begin
          wr_hit[c] = 1'b1;
        end else begin
          wr_bad[c] = 1'b1;
        end
      end
      for (int unsigned a = 0; a < DEPTH; a++) begin
        if (wr_hit[c] && wa[c] == ADDR_W'(a) && mask[c][a]) begin
          wr_ovw[c] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      for (int unsigned a = 0; a < DEPTH; a++) begin
        if (rd_ch == CH_W'(c) && rd_addr == ADDR_W'(a)) begin
          rd_mux = mem[c][a];
        end
      end
    end
  end

  always_comb begin
    cmp_miss = 1'b0;
    for (int unsigned c = 1; c < NUM_CH; c++) begin
      if (mem[c][idx] != mem[0][idx]) begin
        cmp_miss = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_memory_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      mismatch  <= 1'b0;
      mism_addr <= '0;
      cmp_busy  <= 1'b0;
      cmp_done  <= 1'b0;
      all_match <= 1'b0;
      ovw_err   <= 1'b0;
      addr_err  <= 1'b0;
      rd_data   <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        mask[c] <= '0;
        for (int unsigned a = 0; a < DEPTH; a++) begin
          mem[c][a] <= '0;
        end
      end
    end else begin
      if (rd_en) begin
        rd_data <= rd_mux;
      end
      if (clr) begin
        // clr wins over any same-cycle write; bank contents are kept.
        state     <= S_IDLE;
        idx       <= '0;
        mismatch  <= 1'b0;
        mism_addr <= '0;
        cmp_busy  <= 1'b0;
        cmp_done  <= 1'b0;
        all_match <= 1'b0;
        ovw_err   <= 1'b0;
        addr_err  <= 1'b0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          mask[c] <= '0;
        end
      end else begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          for (int unsigned a = 0; a < DEPTH; a++) begin
            if (wr_hit[c] && wa[c] == ADDR_W'(a)) begin
              mem[c][a]  <= wd[c];
              mask[c][a] <= 1'b1;
            end
          end
        end
        if (|wr_ovw) ovw_err  <= 1'b1;
        if (|wr_bad) addr_err <= 1'b1;

        case (state)
          S_IDLE: begin
            if (&ch_done) begin
              state     <= S_COMPARE;
              idx       <= '0;
              mismatch  <= 1'b0;
              mism_addr <= '0;
              cmp_busy  <= 1'b1;
            end
          end
          S_COMPARE: begin
            if (cmp_miss && !mismatch) begin
              mismatch  <= 1'b1;
              mism_addr <= idx;
            end
            if (idx == ADDR_W'(DEPTH - 1)) begin
              state     <= S_DONE;
              cmp_busy  <= 1'b0;
              cmp_done  <= 1'b1;
              all_match <= ~(mismatch | cmp_miss);
            end else begin
              idx <= idx + 1'b1;
            end
          end
          S_DONE: begin
            state <= S_DONE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_result_memory_bank.sv
module tb_result_memory_bank;

  logic        clk = 1'b0;
  logic        rst_memory_n;
  logic        clr;
  logic [2:0]  wr_valid;
  logic        wr_ready;
  logic [5:0]  wr_addr;
  logic [23:0] wr_data;
  logic        rd_en;
  logic [1:0]  rd_ch;
  logic [1:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [2:0]  ch_done;
  logic        cmp_busy;
  logic        cmp_done;
  logic        all_match;
  logic [1:0]  mism_addr;
  logic        ovw_err;
  logic        addr_err;

  // 3x3 instance: 4-bit addresses can exceed DEPTH=9, exercising addr_err.
  logic        clr3;
  logic [2:0]  wr_valid3;
  logic        wr_ready3;
  logic [11:0] wr_addr3;
  logic [23:0] wr_data3;
  logic        rd_en3;
  logic [1:0]  rd_ch3;
  logic [3:0]  rd_addr3;
  logic [7:0]  rd_data3;
  logic [2:0]  ch_done3;
  logic        cmp_busy3;
  logic        cmp_done3;
  logic        all_match3;
  logic [3:0]  mism_addr3;
  logic        ovw_err3;
  logic        addr_err3;

  int tests_run = 0;
  int tests_failed = 0;
  int busy_cnt;

  always #5 clk = ~clk;

  result_memory_bank #(.DATA_W(8), .NUM_CH(3), .OUT_DIM(2)) u_dut (
    .clk(clk), .rst_memory_n(rst_memory_n), .clr(clr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_data(rd_data),
    .ch_done(ch_done), .cmp_busy(cmp_busy), .cmp_done(cmp_done),
    .all_match(all_match), .mism_addr(mism_addr),
    .ovw_err(ovw_err), .addr_err(addr_err)
  );

  result_memory_bank #(.DATA_W(8), .NUM_CH(3), .OUT_DIM(3)) u_dut3 (
    .clk(clk), .rst_memory_n(rst_memory_n), .clr(clr3),
    .wr_valid(wr_valid3), .wr_ready(wr_ready3), .wr_addr(wr_addr3), .wr_data(wr_data3),
    .rd_en(rd_en3), .rd_ch(rd_ch3), .rd_addr(rd_addr3), .rd_data(rd_data3),
    .ch_done(ch_done3), .cmp_busy(cmp_busy3), .cmp_done(cmp_done3),
    .all_match(all_match3), .mism_addr(mism_addr3),
    .ovw_err(ovw_err3), .addr_err(addr_err3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one write per channel (channel 0 first in the argument list).
  task automatic wr(input logic [2:0] v,
                    input logic [1:0] a0, input logic [1:0] a1, input logic [1:0] a2,
                    input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    wr_valid = v;
    wr_addr  = {a2, a1, a0};
    wr_data  = {d2, d1, d0};
  endtask

  task automatic rd(input logic [1:0] ch, input logic [1:0] a);
    rd_en = 1'b1; rd_ch = ch; rd_addr = a;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    logic [7:0] tbl [4];
    tbl[0] = 8'h11; tbl[1] = 8'h22; tbl[2] = 8'h33; tbl[3] = 8'h44;

    rst_memory_n = 1'b0; clr = 1'b0; rd_en = 1'b0; rd_ch = '0; rd_addr = '0;
    wr('0, 0, 0, 0, 0, 0, 0);
    clr3 = 1'b0; wr_valid3 = '0; wr_addr3 = '0; wr_data3 = '0;
    rd_en3 = 1'b0; rd_ch3 = '0; rd_addr3 = '0;

    // Reset defaults
    tick(); tick();
    chk("rst_rd_data",   32'(rd_data),   0);
    chk("rst_ch_done",   32'(ch_done),   0);
    chk("rst_cmp_busy",  32'(cmp_busy),  0);
    chk("rst_cmp_done",  32'(cmp_done),  0);
    chk("rst_all_match", 32'(all_match), 0);
    chk("rst_mism_addr", 32'(mism_addr), 0);
    chk("rst_ovw_err",   32'(ovw_err),   0);
    chk("rst_addr_err",  32'(addr_err),  0);
    chk("rst_wr_ready",  32'(wr_ready),  1);
    rst_memory_n = 1'b1;
    tick();
    rd(2'd2, 2'd3);
    chk("rst_read_zero", 32'(rd_data), 0);

    // Single write then read
    wr(3'b001, 0, 0, 0, 8'hAA, 0, 0);
    tick();
    wr('0, 0, 0, 0, 0, 0, 0);
    chk("single_ch_done", 32'(ch_done), 0);
    rd(2'd0, 2'd0);
    chk("single_rd_data", 32'(rd_data), 32'h0000_00AA);

    // Full match across all three channels
    pulse_clr();
    for (int i = 0; i < 4; i++) begin
      wr(3'b111, 2'(i), 2'(i), 2'(i), tbl[i], tbl[i], tbl[i]);
      tick();
    end
    wr('0, 0, 0, 0, 0, 0, 0);
    chk("match_ch_done",  32'(ch_done),  32'b111);
    chk("match_busy_pre", 32'(cmp_busy), 0);
    busy_cnt = 0;
    for (int i = 0; i < 12 && !cmp_done; i++) begin
      tick();
      if (cmp_busy) busy_cnt++;
    end
    chk("match_busy_cycles", 32'(busy_cnt),  4);
    chk("match_cmp_done",    32'(cmp_done),  1);
    chk("match_all_match",   32'(all_match), 1);
    chk("match_mism_addr",   32'(mism_addr), 0);
    chk("match_wr_ready",    32'(wr_ready),  0);

    // Mismatch: ch2 addr 2 and ch1 addr 3 differ; first one wins
    pulse_clr();
    for (int i = 0; i < 4; i++) begin
      wr(3'b111, 2'(i), 2'(i), 2'(i), tbl[i],
         (i == 3) ? 8'h00 : tbl[i], (i == 2) ? 8'h30 : tbl[i]);
      tick();
    end
    wr('0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12 && !cmp_done; i++) tick();
    chk("mism_cmp_done",  32'(cmp_done),  1);
    chk("mism_all_match", 32'(all_match), 0);
    chk("mism_mism_addr", 32'(mism_addr), 2);
    rd(2'd2, 2'd2);
    chk("mism_rd_ch2_a2", 32'(rd_data), 32'h30);

    // Overwrite error
    pulse_clr();
    chk("ovw_cleared_done", 32'(cmp_done), 0);
    wr(3'b001, 1, 0, 0, 8'h55, 0, 0);
    tick();
    chk("ovw_first_no_err", 32'(ovw_err), 0);
    wr(3'b001, 1, 0, 0, 8'h66, 0, 0);
    tick();
    wr('0, 0, 0, 0, 0, 0, 0);
    chk("ovw_err_set", 32'(ovw_err), 1);
    chk("ovw_ch_done", 32'(ch_done), 0);
    rd(2'd0, 2'd1);
    chk("ovw_rd_data", 32'(rd_data), 32'h66);

    // Address error on the 3x3 instance: ch1 addr 12 >= DEPTH 9
    chk("aerr_before", 32'(addr_err3), 0);
    wr_valid3 = 3'b010; wr_addr3 = {4'd0, 4'd12, 4'd0}; wr_data3 = {8'h0, 8'h5A, 8'h0};
    tick();
    wr_valid3 = '0;
    chk("aerr_set",     32'(addr_err3), 1);
    chk("aerr_ch_done", 32'(ch_done3),  0);
    chk("aerr_no_ovw",  32'(ovw_err3),  0);
    rd_en3 = 1'b1; rd_ch3 = 2'd1; rd_addr3 = 4'd12;
    tick();
    chk("aerr_rd_oob_addr", 32'(rd_data3), 0);
    rd_ch3 = 2'd3; rd_addr3 = 4'd0;
    tick();
    rd_en3 = 1'b0;
    chk("rd_oob_ch", 32'(rd_data3), 0);

    // clr collides with a write: write is dropped
    clr = 1'b1;
    wr(3'b001, 0, 0, 0, 8'h77, 0, 0);
    tick();
    clr = 1'b0;
    wr('0, 0, 0, 0, 0, 0, 0);
    chk("clrw_ch_done", 32'(ch_done), 0);
    chk("clrw_ovw_err", 32'(ovw_err), 0);
    rd(2'd0, 2'd0);
    chk("clrw_data_kept", 32'(rd_data), 32'h11);
    wr(3'b001, 0, 0, 0, 8'h12, 0, 0);
    tick();
    wr('0, 0, 0, 0, 0, 0, 0);
    chk("clrw_mask_was_clear", 32'(ovw_err), 0);

    // clr in the middle of a compare
    pulse_clr();
    for (int i = 0; i < 4; i++) begin
      wr(3'b111, 2'(i), 2'(i), 2'(i), tbl[i], tbl[i], tbl[i]);
      tick();
    end
    wr('0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("abort_busy_before", 32'(cmp_busy), 1);
    pulse_clr();
    chk("abort_busy",     32'(cmp_busy), 0);
    chk("abort_done",     32'(cmp_done), 0);
    chk("abort_wr_ready", 32'(wr_ready), 1);
    chk("abort_ch_done",  32'(ch_done),  0);
    tick(); tick(); tick(); tick();
    chk("abort_done_later", 32'(cmp_done), 0);
    rd(2'd1, 2'd3);
    chk("abort_data_kept", 32'(rd_data), 32'h44);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
